// File: rtl/uart_pkg.sv
// Shared UART receiver types and bit-timing helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic circular-buffer FIFO with push/overflow on the write side and valid/ready pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push,
  output logic             overflow,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  input  logic             ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid    = !empty;
  assign pop      = valid && ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign wr_en    = push && (!full || pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      overflow <= push && full && !pop;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with majority-filtered sampling feeding a byte FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rxd,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       break_o,
  output logic       overflow_o,
  output logic       rx_busy_o
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned TW  = $clog2(CPB);
  localparam logic [TW-1:0] T_FULL = TW'(CPB - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CPB / 2 - 1);

  logic          sync1;
  logic          sync2;
  logic [2:0]    taps;
  logic          sample;
  logic          prev_sample;
  rx_state_t     state;
  logic [TW-1:0] timer;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          push;

  assign sample    = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
  assign push      = (state == STOP) && (timer == T_FULL) && sample;
  assign rx_busy_o = (state != IDLE);

  // After a bad stop bit the line may still be low; prev_sample stays 0 until the line
  // is seen high, so a held break cannot re-trigger a frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      taps        <= 3'b111;
      prev_sample <= 1'b1;
      state       <= IDLE;
      timer       <= '0;
      idx         <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
      break_o     <= 1'b0;
    end else begin
      sync1       <= uart_rxd;
      sync2       <= sync1;
      taps        <= {taps[1:0], sync2};
      prev_sample <= sample;
      frame_err_o <= 1'b0;
      break_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (prev_sample && !sample) begin
            state <= START;
            timer <= '0;
          end
        end
        START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            idx   <= '0;
            state <= sample ? IDLE : DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (timer == T_FULL) begin
            timer <= '0;
            shreg <= {sample, shreg[7:1]};
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (timer == T_FULL) begin
            timer <= '0;
            state <= IDLE;
            if (!sample) begin
              frame_err_o <= 1'b1;
              break_o     <= (shreg == 8'h00);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push_data (shreg),
    .push      (push),
    .overflow  (overflow_o),
    .pop_data  (rx_data_o),
    .valid     (rx_valid_o),
    .ready     (rx_ready_i)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo against a queue-based frame model.
module tb_uart_rx_fifo;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       brk;
  logic       ovf;
  logic       busy;

  uart_rx_fifo #(
    .CLK_FREQ   (1_600_000),
    .BAUD_RATE  (100_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .uart_rxd    (rxd),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (ready),
    .frame_err_o (frame_err),
    .break_o     (brk),
    .overflow_o  (ovf),
    .rx_busy_o   (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int fe_cnt = 0;
  int br_cnt = 0;
  int ov_cnt = 0;
  int vcyc = 0;
  int cyc = 0;
  int last_rise = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #1;
    if (rx_valid && ready) got_q.push_back(rx_data);
    if (rx_valid) vcyc++;
    if (rx_valid && !prev_valid) last_rise = cyc;
    prev_valid = rx_valid;
    if (frame_err) fe_cnt++;
    if (brk) begin
      br_cnt++;
      check("break_with_frame_err", 32'(frame_err), 32'd1);
    end
    if (ovf) ov_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop;
    idle(CPB);
    rxd = 1'b1;
  endtask

  task automatic compare_out(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fe0, br0, ov0, lat, t0, efe, ebr;
    logic [7:0] b;
    logic good;

    @(negedge clk);
    rst = 1'b1;
    idle(3);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_flags", {29'd0, frame_err, brk, ovf}, 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    idle(4);

    // 1: single clean byte, consumer always ready
    ready = 1'b1;
    vcyc = 0;
    send(8'hA5, 1'b1);
    idle(CPB);
    exp_q.push_back(8'hA5);
    compare_out("t1_data");
    check("t1_valid_cycles", 32'(vcyc), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_flags", 32'(fe_cnt + br_cnt + ov_cnt), 32'd0);

    // 2: glitches shorter than half a bit
    fe0 = fe_cnt; br0 = br_cnt; ov0 = ov_cnt;
    rxd = 1'b0; idle(1); rxd = 1'b1; idle(40);
    rxd = 1'b0; idle(6); rxd = 1'b1; idle(40);
    check("t2_no_byte", 32'(got_q.size()), 32'd0);
    check("t2_no_flags", 32'(fe_cnt + br_cnt + ov_cnt - fe0 - br0 - ov0), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);

    // 3: low stop bit on non-zero data
    fe0 = fe_cnt; br0 = br_cnt;
    send(8'h3C, 1'b0);
    idle(CPB);
    check("t3_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("t3_break", 32'(br_cnt - br0), 32'd0);
    check("t3_empty", 32'(rx_valid), 32'd0);
    check("t3_no_byte", 32'(got_q.size()), 32'd0);

    // 4: long break, then normal traffic
    fe0 = fe_cnt; br0 = br_cnt;
    rxd = 1'b0;
    idle(20 * CPB);
    check("t4_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("t4_break", 32'(br_cnt - br0), 32'd1);
    rxd = 1'b1;
    idle(2 * CPB);
    send(8'h55, 1'b1);
    idle(CPB);
    exp_q.push_back(8'h55);
    compare_out("t4_data");

    // 5: fill with consumer stalled, fifth byte overflows
    ready = 1'b0;
    ov0 = ov_cnt;
    t0 = cyc;
    send(8'h01, 1'b1);
    lat = last_rise - t0;
    check("t5_latency_window", 32'(lat >= 152 && lat <= 162), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      send(8'(i), 1'b1);
      idle(4);
    end
    check("t5_no_ovf_yet", 32'(ov_cnt - ov0), 32'd0);
    send(8'h05, 1'b1);
    idle(CPB);
    check("t5_ovf_once", 32'(ov_cnt - ov0), 32'd1);
    ready = 1'b1;
    idle(8);
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    compare_out("t5_drain");
    check("t5_empty", 32'(rx_valid), 32'd0);

    // 6a: pop coincides with the push into a full FIFO
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 1'b1);
      idle(4);
    end
    fork
      send(8'h05, 1'b1);
      begin
        idle(lat - 1);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
      end
    join
    idle(CPB);
    check("t6_no_ovf", 32'(ov_cnt - ov0), 32'd0);
    ready = 1'b1;
    idle(8);
    ready = 1'b0;
    exp_q.push_back(8'h01);
    for (int i = 2; i <= 5; i++) exp_q.push_back(8'(i));
    compare_out("t6_order");

    // 6b: reset in the middle of data bit 4 flushes everything
    send(8'h11, 1'b1);
    idle(4);
    send(8'h22, 1'b1);
    idle(4);
    fe0 = fe_cnt; br0 = br_cnt; ov0 = ov_cnt;
    b = 8'hC3;
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = b[4];
    idle(CPB / 2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    rxd = 1'b1;
    idle(3 * CPB);
    check("t6_reset_empty", 32'(rx_valid), 32'd0);
    check("t6_reset_busy", 32'(busy), 32'd0);
    check("t6_reset_pulses", 32'(fe_cnt + br_cnt + ov_cnt - fe0 - br0 - ov0), 32'd0);
    ready = 1'b1;
    send(8'h7E, 1'b1);
    idle(CPB);
    exp_q.push_back(8'h7E);
    compare_out("t6_after_reset");

    // random frames against the model: good stop -> byte in order, bad stop -> error (+break on 0x00)
    fe0 = fe_cnt; br0 = br_cnt; ov0 = ov_cnt;
    efe = 0; ebr = 0;
    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      if (i % 5 == 4) begin
        b = 8'h00;
        good = 1'b0;
      end
      if (good) exp_q.push_back(b);
      else begin
        efe++;
        if (b == 8'h00) ebr++;
      end
      send(b, good);
      idle($urandom_range(4, 30));
    end
    idle(CPB);
    compare_out("rand_data");
    check("rand_frame_err", 32'(fe_cnt - fe0), 32'(efe));
    check("rand_break", 32'(br_cnt - br0), 32'(ebr));
    check("rand_no_ovf", 32'(ov_cnt - ov0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
